// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
// Shared definitions for the APB-to-register bridge and its watchdog:
//   - state_e           : bridge FSM state encoding (2 bits)
//   - DEFAULT_ERR_DATA  : read data returned when the watchdog aborts an access
//   - cnt_width()       : watchdog counter width for a given timeout
// -----------------------------------------------------------------------------
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Width needed to hold 0..TIMEOUT_CYCLES; never narrower than one bit so
    // that a disabled watchdog (TIMEOUT_CYCLES = 0) still has a legal vector.
    function automatic int cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_bus_timeout_cnt.sv
// -----------------------------------------------------------------------------
// reg_bus_timeout_cnt
// Saturating watchdog counter for the register bridge.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   clr      in  restart the count at zero (priority over en)
//   en       in  count one cycle
//   expired  out count has reached TIMEOUT_CYCLES-1 (never set when
//                TIMEOUT_CYCLES = 0)
// -----------------------------------------------------------------------------
module reg_bus_timeout_cnt
    import reg_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stops at all-ones instead of wrapping, so a disabled or stuck watchdog
    // can never alias back onto the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
            assign expired = 1'b0;
        end else begin : g_wdog
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
            assign expired = (cnt_q == LAST_CNT);
        end
    endgenerate

endmodule

// File: rtl/apb2reg_mst_bridge.sv
// -----------------------------------------------------------------------------
// apb2reg_mst_bridge
// APB3 completer that converts each APB access into one native register
// request/acknowledge exchange, with a watchdog that aborts a hung access.
// Ports:
//   clk, rst                     clock / synchronous active-high reset
//   psel, penable, pwrite,
//   paddr, pwdata                APB request inputs
//   pready, prdata, pslverr      APB completion (one-cycle pready pulse)
//   req_vld_m / req_rdy_m        native request handshake
//   rd_en, wr_en, addr, wr_data  native request payload
//   ack_vld_m / ack_rdy_m        native acknowledge handshake
//   rd_data                      native read data, valid with ack_vld_m
//   g_srst                       one-cycle soft-reset pulse after a timeout
// -----------------------------------------------------------------------------
module apb2reg_mst_bridge
    import reg_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 64,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld_m,
    input  logic                  req_rdy_m,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ack_vld_m,
    output logic                  ack_rdy_m,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  g_srst
);

    // Zero-extends or truncates the 32-bit error pattern to the bus width.
    localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERR_DATA);

    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    pwrite_q,  pwrite_d;
    logic                    rd_en_q,   rd_en_d;
    logic                    wr_en_q,   wr_en_d;
    logic                    pready_q,  pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic                    g_srst_q,  g_srst_d;

    logic apb_setup;
    logic wdog_clr;
    logic wdog_en;
    logic wdog_expired;

    assign apb_setup = psel && !penable;
    assign wdog_clr  = (state_q == ST_IDLE) && apb_setup;
    assign wdog_en   = (state_q == ST_REQ) || (state_q == ST_ACK);

    reg_bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        pwrite_d  = pwrite_q;
        // Completion outputs are single-cycle: they fall back to zero unless
        // this cycle is the transition into DONE.
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        g_srst_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (apb_setup) begin
                    state_d   = ST_REQ;
                    addr_d    = paddr;
                    wr_data_d = pwdata;
                    pwrite_d  = pwrite;
                end
            end

            ST_REQ, ST_ACK: begin
                // An acknowledge is honoured even in REQ (early ack) and
                // always beats a watchdog expiry in the same cycle.
                if (ack_vld_m) begin
                    state_d  = ST_DONE;
                    pready_d = 1'b1;
                    prdata_d = pwrite_q ? '0 : rd_data;
                end else if (wdog_expired) begin
                    state_d   = ST_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = ERR_DATA_W;
                    g_srst_d  = 1'b1;
                end else if ((state_q == ST_REQ) && req_rdy_m) begin
                    state_d = ST_ACK;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered copies of "next state is REQ" so they line
        // up exactly with the req_vld_m state decode.
        rd_en_d = (state_d == ST_REQ) && !pwrite_d;
        wr_en_d = (state_d == ST_REQ) &&  pwrite_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            pwrite_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            g_srst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            pwrite_q  <= pwrite_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            g_srst_q  <= g_srst_d;
        end
    end

    assign req_vld_m = (state_q == ST_REQ);
    assign ack_rdy_m = (state_q == ST_ACK);
    assign rd_en     = rd_en_q;
    assign wr_en     = wr_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign pready    = pready_q;
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign g_srst    = g_srst_q;

endmodule

// File: tb/tb_apb2reg_mst_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb2reg_mst_bridge
// Directed bench for apb2reg_mst_bridge with an 8-cycle watchdog.
// Cycle numbering: the APB setup phase is cycle 0; outputs are sampled 1 time
// unit after each rising edge and inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_apb2reg_mst_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [63:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        req_vld_m;
    logic        req_rdy_m = 1'b0;
    logic        rd_en;
    logic        wr_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic        ack_vld_m = 1'b0;
    logic        ack_rdy_m;
    logic [31:0] rd_data = '0;
    logic        g_srst;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    apb2reg_mst_bridge #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .req_vld_m (req_vld_m),
        .req_rdy_m (req_rdy_m),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .ack_vld_m (ack_vld_m),
        .ack_rdy_m (ack_rdy_m),
        .rd_data   (rd_data),
        .g_srst    (g_srst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pready"},    {63'd0, pready},    64'd0);
        chk({tag, ".prdata"},    {32'd0, prdata},    64'd0);
        chk({tag, ".pslverr"},   {63'd0, pslverr},   64'd0);
        chk({tag, ".g_srst"},    {63'd0, g_srst},    64'd0);
        chk({tag, ".req_vld_m"}, {63'd0, req_vld_m}, 64'd0);
        chk({tag, ".ack_rdy_m"}, {63'd0, ack_rdy_m}, 64'd0);
        chk({tag, ".rd_en"},     {63'd0, rd_en},     64'd0);
        chk({tag, ".wr_en"},     {63'd0, wr_en},     64'd0);
        chk({tag, ".addr"},      addr,               64'd0);
        chk({tag, ".wr_data"},   {32'd0, wr_data},   64'd0);
    endtask

    // One APB transaction plus a scripted downstream responder.
    //   rdy_dly : REQ cycles with req_rdy_m low before it rises
    //   ack_dly : ACK cycles before ack_vld_m; -1 = early ack while in REQ
    //   exp_err : the watchdog is expected to abort this access
    task automatic xfer(input bit wr, input logic [63:0] a, input logic [31:0] d,
                        input int rdy_dly, input int ack_dly, input logic [31:0] rdv,
                        input bit drop_psel, input bit exp_err);
        int          n;
        int          hs_cyc;
        int          vld_cycles;
        int          srst_cnt;
        int          lat_exp;
        int          vld_exp;
        bit          done;
        logic [31:0] exp_prdata;

        lat_exp    = exp_err ? 9 : ((ack_dly < 0) ? 2 : 3 + rdy_dly + ack_dly);
        vld_exp    = (ack_dly < 0) ? 1 : rdy_dly + 1;
        exp_prdata = exp_err ? 32'hDEAD_BEEF : (wr ? 32'h0 : rdv);

        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        tick();
        psel    = !drop_psel;
        penable = !drop_psel;

        n = 0; hs_cyc = -1; vld_cycles = 0; srst_cnt = 0; done = 1'b0;
        while (!done && n < 40) begin
            if (g_srst) srst_cnt++;
            if (pready) begin
                done = 1'b1;
            end else begin
                if (req_vld_m) begin
                    vld_cycles++;
                    chk("req.addr",    addr,              a);
                    chk("req.wr_data", {32'd0, wr_data},  {32'd0, d});
                    chk("req.wr_en",   {63'd0, wr_en},    {63'd0, wr});
                    chk("req.rd_en",   {63'd0, rd_en},    {63'd0, !wr});
                end
                chk("rd_wr_excl", {63'd0, rd_en & wr_en}, 64'd0);
                req_rdy_m = req_vld_m && (ack_dly >= 0) && (n >= rdy_dly);
                ack_vld_m = (ack_dly < 0) || ((hs_cyc >= 0) && (n - hs_cyc - 1 >= ack_dly));
                rd_data   = ack_vld_m ? rdv : ~rdv;
                if (req_vld_m && req_rdy_m) hs_cyc = n;
                tick();
                n++;
            end
        end

        chk("pready_seen", {63'd0, done}, 64'd1);
        chk("latency",     64'(n + 1),    64'(lat_exp));
        chk("req_vld_cyc", 64'(vld_cycles), 64'(vld_exp));
        chk("pslverr",     {63'd0, pslverr}, {63'd0, exp_err});
        chk("prdata",      {32'd0, prdata},  {32'd0, exp_prdata});
        chk("done.req_vld_m", {63'd0, req_vld_m}, 64'd0);
        chk("done.ack_rdy_m", {63'd0, ack_rdy_m}, 64'd0);
        $display("xfer wr=%0d addr=0x%0h wdata=0x%0h lat=%0d pslverr=%0d prdata=0x%0h",
                 wr, a, d, n + 1, pslverr, prdata);

        psel      = 1'b0;
        penable   = 1'b0;
        req_rdy_m = 1'b0;
        ack_vld_m = 1'b0;
        tick();
        if (g_srst) srst_cnt++;
        chk("after.pready",  {63'd0, pready},  64'd0);
        chk("after.prdata",  {32'd0, prdata},  64'd0);
        chk("after.pslverr", {63'd0, pslverr}, 64'd0);
        chk("g_srst_pulses", 64'(srst_cnt),    64'(exp_err ? 1 : 0));
    endtask

    initial begin
        logic [63:0] ra;
        logic [31:0] rd;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Write, zero wait: pready at cycle 3
        xfer(1'b1, 64'h10, 32'hA5A5_0001, 0, 0, 32'h0, 1'b0, 1'b0);
        // Read with 4 cycles of request backpressure, req_vld_m held 5 cycles
        xfer(1'b0, 64'h20, 32'h0, 4, 1, 32'h1234_5678, 1'b0, 1'b0);
        // Early acknowledge while still in REQ
        xfer(1'b0, 64'h30, 32'h0, 0, -1, 32'hCAFE_0003, 1'b0, 1'b0);
        // Never acknowledged: watchdog abort 9 cycles after setup
        xfer(1'b0, 64'h44, 32'h0, 0, 100, 32'h5555_0000, 1'b0, 1'b1);
        // Normal transaction right after the abort
        xfer(1'b1, 64'h48, 32'h0BAD_F00D, 1, 0, 32'h0, 1'b0, 1'b0);
        // Ack coincides with count 7: ack wins
        xfer(1'b0, 64'h50, 32'h0, 0, 6, 32'h600D_F00D, 1'b0, 1'b0);
        // Ack one cycle too late: timeout on a write
        xfer(1'b1, 64'h54, 32'h0000_0001, 0, 7, 32'h0, 1'b0, 1'b1);
        // APB master drops psel after setup; access still completes
        xfer(1'b1, 64'h58, 32'h0000_0077, 1, 1, 32'h0, 1'b1, 1'b0);

        // Reset while in ACK: everything clears, no pready, no g_srst
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 64'h40;
        pwdata  = 32'h0;
        tick();
        penable   = 1'b1;
        req_rdy_m = 1'b1;
        tick();
        chk("rst_mid.ack_rdy_m", {63'd0, ack_rdy_m}, 64'd1);
        req_rdy_m = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        // New setup accepted in the first cycle out of reset
        xfer(1'b1, 64'h60, 32'h0000_0060, 0, 0, 32'h0, 1'b0, 1'b0);

        // Back-to-back random write/read pairs against a register-file model
        for (int i = 0; i < 100; i++) begin
            ra = {$urandom, $urandom};
            rd = $urandom;
            xfer(1'b1, ra, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 32'h0, 1'b0, 1'b0);
            xfer(1'b0, ra, 32'h0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 rd, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/apb2reg_mst_bridge.md
Name: apb2reg_mst_bridge

Overview:
Upstream neighbour of the register-slave FSM. Converts an APB3 completer transaction into the native register handshake: request channel (req_vld/req_rdy with rd_en/wr_en/addr/wr_data) and acknowledge channel (ack_vld/ack_rdy with rd_data). Includes a watchdog that turns a hung downstream access into an APB error plus a one-cycle global soft-reset pulse. One bridge per register tree.

Parameters:
ADDR_WIDTH, 64, APB and native address width
DATA_WIDTH, 32, APB and native data width
TIMEOUT_CYCLES, 256, cycles from request launch to forced abort; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, prdata value returned on timeout (truncated or zero-extended to DATA_WIDTH)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB 1=write, 0=read
paddr  in  ADDR_WIDTH  APB address
pwdata  in  DATA_WIDTH  APB write data
pready  out  1  APB completion
prdata  out  DATA_WIDTH  APB read data
pslverr  out  1  APB error, valid with pready
req_vld_m  out  1  native request valid
req_rdy_m  in  1  native request ready
rd_en  out  1  native read strobe, qualified by req_vld_m
wr_en  out  1  native write strobe, qualified by req_vld_m
addr  out  ADDR_WIDTH  native address (registered)
wr_data  out  DATA_WIDTH  native write data (registered)
ack_vld_m  in  1  native acknowledge valid
ack_rdy_m  out  1  native acknowledge ready
rd_data  in  DATA_WIDTH  native read data, valid with ack_vld_m
g_srst  out  1  global soft-reset pulse to the register tree

Behaviour:
- Everything is synchronous to clk. rst is sampled on the clock edge. On reset: state=IDLE, all outputs 0, and the address/data/timeout registers are 0. A reset mid-transaction aborts it silently: no pready and no g_srst.
- States are IDLE, REQ, ACK, DONE.
- IDLE: on psel & !penable (APB setup), capture paddr, pwdata and pwrite, then go to REQ. Any other psel/penable combination is ignored.
- REQ: req_vld_m=1, wr_en=pwrite_q, rd_en=!pwrite_q. addr and wr_data are held stable.
  - A handshake occurs in a cycle where req_vld_m & req_rdy_m. Go to ACK; req_vld_m drops the next cycle.
  - If ack_vld_m arrives while still in REQ (downstream early ack), treat it as the acknowledge: capture data and go to DONE.
- ACK: ack_rdy_m=1. On ack_vld_m: prdata <= pwrite_q ? 0 : rd_data, pslverr <= 0, go to DONE.
- DONE: pready=1 for exactly one cycle, with prdata/pslverr valid, then go to IDLE. prdata returns to 0 on the next cycle.
- Minimum latency: setup at cycle 0 → req_vld_m at cycle 1. With req_rdy_m=1 and ack at cycle 2, pready is at cycle 3.
- Watchdog:
  - Counter clears on IDLE→REQ and increments every cycle in REQ or ACK.
  - When count == TIMEOUT_CYCLES-1 and no ack arrives that cycle: go to DONE with pslverr=1 and prdata=ERR_DATA. g_srst=1 for that single transition cycle. req_vld_m and ack_rdy_m drop.
  - If ack_vld_m and the timeout coincide, the ack wins and there is no error.
  - TIMEOUT_CYCLES=0 means the counter never fires. The counter saturates and does not wrap.
- APB master may deassert psel before pready (protocol violation). The transaction still completes downstream and the pready pulse is still produced.
- Outputs are registered except ack_rdy_m and req_vld_m, which are state decodes.

Decomposition:
- Shared package reg_bus_pkg: state enum (IDLE/REQ/ACK/DONE, 2 bits), default ERR_DATA localparam, and the watchdog width function clog2(TIMEOUT_CYCLES+1).
- One sub-module, reg_bus_timeout_cnt: saturating counter with clear, enable, and an expiry flag. Parameter TIMEOUT_CYCLES.
- FSM and datapath stay in the top module.

Test Plan:
- Write, zero wait: setup paddr=0x10, pwdata=0xA5A5_0001, req_rdy_m=1, ack_vld_m at cycle 2 → req_vld_m/wr_en at cycle 1 with addr=0x10, wr_data=0xA5A5_0001; pready=1, pslverr=0 at cycle 3.
- Read with backpressure: req_rdy_m low 4 cycles, ack 3 cycles later with rd_data=0x1234_5678 → req_vld_m held 5 cycles with addr stable; prdata=0x1234_5678 with pready; rd_en never with wr_en.
- Timeout: TIMEOUT_CYCLES=8, never ack → exactly one g_srst pulse, pready=1, pslverr=1, prdata=0xDEAD_BEEF, 9 cycles after setup. Next transaction completes normally.
- Ack and timeout in the same cycle at count 7 → pslverr=0, prdata=rd_data, no g_srst.
- Reset while in ACK → all outputs 0 the next cycle, no pready. A new setup is accepted immediately after.
- Back-to-back: second setup on the cycle after pready → second req_vld_m one cycle later. No lost or duplicated transaction; 100 random read/write pairs match a scoreboard.
